// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pkg : shared scan-FSM encoding, off-levels and hex glyph table       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seg_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } seg_state_e;

  // Pins are active-low, so "off" is all ones.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic       AN_OFF  = 1'b1;

  // Active-high gfedcba patterns; entry i is the glyph for hex value i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_decode : combinational 4-bit hex to active-high 7-segment glyph      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_TABLE[i_hex];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_ctrl : frame-snapshotted multiplexed 7-seg scan controller      |
// | Optional macro SEG_LZB_EN enables leading-zero blanking.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG   = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NUM_DIG-1:0] digits_in,
  input  logic                 en,
  output logic [NUM_DIG-1:0]   an,
  output logic [6:0]           leds,
  output logic                 frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIG);

  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIG - 1);

  seg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*NUM_DIG-1:0]   snap_q, snap_d;
  logic [NUM_DIG-1:0]     an_q, an_d;
  logic [6:0]             leds_q, leds_d;
  logic                   frame_tick_q, frame_tick_d;

  logic [3:0]             w_digit;
  logic [6:0]             w_glyph;
  logic                   w_lz_blank;

  // Scan sequencing: LOAD -> (BLANK -> SHOW) x NUM_DIG -> LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      ST_LOAD: begin
        snap_d  = digits_in;
        cnt_d   = '0;
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_q == C_BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == C_SHOW_LAST) begin
          cnt_d = '0;
          if (idx_q == C_IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_comb begin
    w_digit = 4'h0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_digit = snap_q[4*i +: 4];
      end
    end
  end

`ifdef SEG_LZB_EN
  // A digit is dark when it and every more-significant digit are zero.
  always_comb begin
    w_lz_blank = 1'b0;
    for (int i = 1; i < NUM_DIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_lz_blank = ((snap_q >> (4*i)) == '0);
      end
    end
  end
`else
  always_comb begin
    w_lz_blank = 1'b0;
  end
`endif

  seg_decode u_seg_decode (
    .i_hex (w_digit),
    .o_seg (w_glyph)
  );

  // Pin values are computed from the current state and registered.
  always_comb begin
    an_d         = {NUM_DIG{AN_OFF}};
    leds_d       = SEG_OFF;
    frame_tick_d = (state_q == ST_LOAD);
    if ((state_q == ST_SHOW) && en && !w_lz_blank) begin
      an_d   = ~(NUM_DIG'(1) << idx_q);
      leds_d = ~w_glyph;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= {NUM_DIG{AN_OFF}};
      leds_q       <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      leds_q       <= leds_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign leds       = leds_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one segment bus (leds) among NUM_DIG digit values. The display value is snapshotted once per frame, so a counter that changes mid-frame never shows a mix of old and new digits. A blanking gap between digits suppresses ghosting. It sits between the board's counter/BCD datapaths and the display pins.

Parameters:
NUM_DIG, 4, number of digits scanned (>=2)
SCAN_DIV, 50000, clk cycles each digit is lit (>=2)
BLANK_CYC, 16, clk cycles all anodes are off before each digit (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
digits_in  in  4*NUM_DIG  hex digit values; digit i = digits_in[4i+3:4i], digit 0 is rightmost
en  in  1  1 = display on; 0 = anodes forced off while scanning continues
an  out  NUM_DIG  anode enables, active-low; an[i] drives digit i
leds  out  7  segments, active-low; leds[0]=a … leds[6]=g
frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset values: an = all 1s, leds = 7'h7F, frame_tick = 0, state = LOAD, idx = 0, cnt = 0, snapshot = 0.
- FSM states:
  - LOAD (1 cycle): snapshot <= digits_in; frame_tick = 1; next state BLANK.
  - BLANK: cnt counts 0..BLANK_CYC-1. At cnt == BLANK_CYC-1, cnt <= 0 and go to SHOW.
  - SHOW: cnt counts 0..SCAN_DIV-1. At terminal count, cnt <= 0. If idx != NUM_DIG-1, idx <= idx+1 and go to BLANK. Otherwise idx <= 0 and go to LOAD.
- Frame length = NUM_DIG*(BLANK_CYC+SCAN_DIV)+1 cycles. frame_tick period equals this exactly.
- Outputs an, leds and frame_tick are registered. They reflect the FSM state of the previous cycle (1-cycle latency, glitch-free pins).
  - While the previous state is SHOW and en = 1: an = ~(1 << idx) and leds = ~glyph(snapshot[idx]).
  - In all other cases: an = all 1s and leds = 7'h7F.
- Glyph table (active-high, gfedcba): full hex 0-F. Values A-F show as A, b, C, d, E, F.
- digits_in is sampled only in LOAD. Changes at any other time have no effect until the next frame.
- en is sampled every cycle. It never stalls the FSM, so frame_tick timing is independent of en.
- idx wraps NUM_DIG-1 -> 0 only through LOAD.
- Reset mid-operation: all registers, including the outputs, go to their reset values immediately (asynchronous). After rst deasserts, the first cycle is LOAD.
- Widths: cnt is wide enough for max(SCAN_DIV, BLANK_CYC)-1; idx is $clog2(NUM_DIG) bits.

Optional Feature:
SEG_LZB_EN: leading-zero blanking.
- Defined: digit i (i > 0) is blanked (its anode stays off) when snapshot digit i and every higher digit are 0. Digit 0 is always shown. Timing is unchanged.
- Undefined: every digit is always shown.

Decomposition:
- Shared package/include seg_pkg:
  - FSM state encoding (LOAD, BLANK, SHOW)
  - SEG_OFF = 7'h7F and AN_OFF constants
  - 16-entry hex glyph constants
- One sub-module, seg_decode: combinational 4-bit hex -> 7-bit active-high segments. It is instantiated once on the muxed digit; inversion happens in seg_scan_ctrl.

Test Plan (NUM_DIG=4, SCAN_DIV=4, BLANK_CYC=2):
- rst=1 held, digits_in=16'hFFFF -> an=4'b1111, leds=7'h7F, frame_tick=0 throughout.
- Release rst, digits_in=16'h1234, en=1 -> first-frame order (1-cycle output latency):
  - frame_tick on cycle 1
  - all anodes off 2 cycles
  - an=4'b1110, leds=7'b0011001 ('4') for 4 cycles
  - 2 blank cycles, then an=4'b1101 showing '3'
  - continues through digits 2 and 3
  - frame_tick pulses every 25 cycles.
- Change digits_in to 16'h9999 during digit 1 SHOW -> digits 2 and 3 still show '2' and '1'. '9' appears only after the next frame_tick.
- en=0 for one full frame -> an=4'b1111 and leds=7'h7F for all 25 cycles, frame_tick still every 25 cycles. With en back to 1, display resumes on the next SHOW.
- Assert rst for 1 cycle mid-SHOW of digit 2 -> outputs off on the same edge. Restart at LOAD with idx=0; next frame_tick occurs 1 cycle after release.
- digits_in=16'h0050:
  - with SEG_LZB_EN: digits 3 and 2 stay off; digit 1 shows '5', digit 0 shows '0'.
  - without SEG_LZB_EN: all four digits are lit as '0','0','5','0'.
